multi_clock_gen: RTL and testbench

//  Multi-channel programmable clock divider. Successor to the single-divisor generator.

---
 rtl/clkgen_pkg.sv | 11 +
 rtl/clk_div_channel.sv | 76 +++++++
 rtl/multi_clock_gen.sv | 51 +++++
 tb/tb_multi_clock_gen.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants and helpers for the multi-channel clock generator.
package clkgen_pkg;
  localparam int          CLKGEN_CNT_W     = 32;
  localparam int          CLKGEN_DEFAULT_M = 7;           // 6.25 MHz from 100 MHz
  localparam int unsigned CLKGEN_SYS_HZ    = 100_000_000;

  // Divisor that yields f_hz at clk_out: half-period is m+1 system cycles.
  function automatic logic [31:0] m_for_freq(input int unsigned f_hz);
    return (CLKGEN_SYS_HZ / 32'd2) / f_hz - 32'd1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor, registered clock and edge ticks.
module clk_div_channel
  import clkgen_pkg::*;
#(
  parameter int CNT_W     = CLKGEN_CNT_W,
  parameter int DEFAULT_M = CLKGEN_DEFAULT_M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_m,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             pend_v
);
  logic [CNT_W-1:0] r_count, r_m_act, r_pend_m;
  logic             r_pend_v, r_clk, r_rise, r_fall;
  logic             w_wrap;

  // Wrap on equality with the divisor, so the all-ones divisor cannot overflow.
  assign w_wrap = (r_count == r_m_act);

  // Count, toggle, and swap in a pending divisor only at a 1->0 wrap (or when forced low).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_m_act  <= CNT_W'(DEFAULT_M);
      r_pend_m <= '0;
      r_pend_v <= 1'b0;
      r_clk    <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // An accept only happens while nothing is pending, so it never races an apply.
      if (wr) begin
        r_pend_m <= wr_m;
        r_pend_v <= 1'b1;
      end
      if (restart) begin
        r_count  <= '0;
        r_clk    <= 1'b0;
        r_pend_v <= 1'b0;
        if (wr)            r_m_act <= wr_m;
        else if (r_pend_v) r_m_act <= r_pend_m;
      end else if (!en) begin
        r_count <= '0;
        r_clk   <= 1'b0;
        if (r_pend_v) begin
          r_m_act  <= r_pend_m;
          r_pend_v <= 1'b0;
        end
      end else begin
        r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
        if (w_wrap) begin
          r_clk  <= ~r_clk;
          r_rise <= ~r_clk;
          r_fall <= r_clk;
          if (r_clk && r_pend_v) begin
            r_m_act  <= r_pend_m;
            r_pend_v <= 1'b0;
          end
        end
      end
    end
  end

  assign clk_out   = r_clk;
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;
  assign pend_v    = r_pend_v;
endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel programmable clock divider: load decode, ready mux, channel array.
module multi_clock_gen
  import clkgen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = CLKGEN_CNT_W,
  parameter int DEFAULT_M = CLKGEN_DEFAULT_M,
  localparam int LCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              basys_clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              load_valid,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_m,
  output logic              load_ready,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_tick,
  output logic [NUM_CH-1:0] fall_tick
);
  logic [NUM_CH-1:0] w_pend_v;
  logic [NUM_CH-1:0] w_wr;
  logic              w_ready;

  // Ready follows the addressed channel's pending flag; unmapped channels always accept.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (load_ch == LCH_W'(i)) w_ready = ~w_pend_v[i];
  end

  assign load_ready = w_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = load_valid && w_ready && (load_ch == LCH_W'(g));

    clk_div_channel #(.CNT_W(CNT_W), .DEFAULT_M(DEFAULT_M)) u_ch (
      .clk       (basys_clk),
      .rst_n     (rst_n),
      .en        (ch_en[g]),
      .restart   (sync_restart),
      .wr        (w_wr[g]),
      .wr_m      (load_m),
      .clk_out   (clk_out[g]),
      .rise_tick (rise_tick[g]),
      .fall_tick (fall_tick[g]),
      .pend_v    (w_pend_v[g])
    );
  end
endmodule

// File: tb/tb_multi_clock_gen.sv
// Self-checking bench: per-cycle scoreboard from a countdown model plus directed edge timing.
module tb_multi_clock_gen;
  localparam int NUM_CH = 3;   // not a power of two, so load_ch=3 is unmapped
  localparam int LCH_W  = 2;

  logic              basys_clk = 1'b0;
  logic              rst_n, sync_restart, load_valid, load_ready;
  logic [NUM_CH-1:0] ch_en, clk_out, rise_tick, fall_tick;
  logic [LCH_W-1:0]  load_ch;
  logic [31:0]       load_m;

  multi_clock_gen #(.NUM_CH(NUM_CH), .CNT_W(32), .DEFAULT_M(7)) dut (
    .basys_clk(basys_clk), .rst_n(rst_n), .ch_en(ch_en), .sync_restart(sync_restart),
    .load_valid(load_valid), .load_ch(load_ch), .load_m(load_m), .load_ready(load_ready),
    .clk_out(clk_out), .rise_tick(rise_tick), .fall_tick(fall_tick)
  );

  always #5 basys_clk = ~basys_clk;

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [NUM_CH-1:0] clk, rise, fall;
    logic              rdy;
  } exp_t;
  exp_t sb[$];

  // Model: cycles remaining until the next toggle, reloaded with m+1.
  logic [NUM_CH-1:0] m_clk, m_rise, m_fall, m_pv;
  logic [31:0]       m_mact [NUM_CH];
  logic [31:0]       m_pm   [NUM_CH];
  longint            m_rem  [NUM_CH];

  always @(posedge basys_clk) begin
    int   lc;
    logic acc, wr;
    exp_t e;
    lc  = int'(load_ch);
    acc = load_valid && ((lc >= NUM_CH) || !m_pv[lc]);
    for (int i = 0; i < NUM_CH; i++) begin
      wr = acc && (lc == i);
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (!rst_n) begin
        m_clk[i] = 1'b0; m_pv[i] = 1'b0; m_pm[i] = '0; m_mact[i] = 32'd7; m_rem[i] = 8;
      end else if (sync_restart) begin
        if (wr)            m_mact[i] = load_m;
        else if (m_pv[i])  m_mact[i] = m_pm[i];
        m_pv[i]  = 1'b0;
        m_clk[i] = 1'b0;
        m_rem[i] = longint'(m_mact[i]) + 1;
      end else if (!ch_en[i]) begin
        if (m_pv[i]) begin m_mact[i] = m_pm[i]; m_pv[i] = 1'b0; end
        if (wr)      begin m_pm[i] = load_m;    m_pv[i] = 1'b1; end
        m_clk[i] = 1'b0;
        m_rem[i] = longint'(m_mact[i]) + 1;
      end else begin
        if (m_rem[i] == 1) begin
          if (m_clk[i] && m_pv[i]) begin m_mact[i] = m_pm[i]; m_pv[i] = 1'b0; end
          m_rise[i] = !m_clk[i];
          m_fall[i] = m_clk[i];
          m_clk[i]  = !m_clk[i];
          m_rem[i]  = longint'(m_mact[i]) + 1;
        end else begin
          m_rem[i] = m_rem[i] - 1;
        end
        if (wr) begin m_pm[i] = load_m; m_pv[i] = 1'b1; end
      end
    end
    e.clk  = m_clk;
    e.rise = m_rise;
    e.fall = m_fall;
    e.rdy  = (lc >= NUM_CH) ? 1'b1 : !m_pv[lc];
    sb.push_back(e);
  end

  // One clock; compare the registered outputs against the scoreboard mid-cycle.
  task automatic cyc();
    exp_t e;
    @(posedge basys_clk);
    @(negedge basys_clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_clk",  64'(clk_out),    64'(e.clk));
      chk("sb_rise", 64'(rise_tick),  64'(e.rise));
      chk("sb_fall", 64'(fall_tick),  64'(e.fall));
      chk("sb_rdy",  64'(load_ready), 64'(e.rdy));
    end
  endtask

  // Cycles until clk_out[ch] reaches lvl, bounded.
  task automatic wait_lvl(input int ch, input logic lvl, output int n);
    n = 0;
    do begin cyc(); n++; end while (clk_out[ch] !== lvl && n < 300);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ch_en = '1; sync_restart = 1'b0;
    load_valid = 1'b0; load_ch = '0; load_m = '0;
    cyc(); cyc();
    chk("rst_clk", 64'(clk_out), 64'd0);
    chk("rst_rdy", 64'(load_ready), 64'd1);

    // Default divisor: rise at cycle 8, fall at 16.
    rst_n = 1'b1;
    wait_lvl(0, 1'b1, n);  chk("t1_rise_at", 64'(n), 64'd8);
    chk("t1_rtick", 64'(rise_tick[0]), 64'd1);
    cyc();                 chk("t1_rtick_w", 64'(rise_tick[0]), 64'd0);
    wait_lvl(0, 1'b0, n);  chk("t1_fall_at", 64'(n), 64'd7);
    chk("t1_ftick", 64'(fall_tick[0]), 64'd1);

    // Load ch1 m=0 mid-high; second load stalls until the 1->0 apply.
    wait_lvl(1, 1'b1, n);  chk("t2_rise", 64'(n), 64'd8);
    cyc(); cyc(); cyc();
    load_valid = 1'b1; load_ch = 2'd1; load_m = 32'd0;
    #1 chk("t2_rdy", 64'(load_ready), 64'd1);
    cyc();
    load_m = 32'd5;
    #1 chk("t3_busy", 64'(load_ready), 64'd0);
    n = 0;
    do begin cyc(); n++; end while (!load_ready && n < 100);
    chk("t3_wait", 64'(n), 64'd4);
    chk("t2_fell", 64'(clk_out[1]), 64'd0);
    cyc();
    load_valid = 1'b0;
    chk("t2_fast", 64'(clk_out[1]), 64'd1);
    repeat (20) cyc();

    // ch0 m=3, ch2 m=1, then restart aligns them.
    load_valid = 1'b1; load_ch = 2'd0; load_m = 32'd3; cyc();
    load_ch = 2'd2; load_m = 32'd1; cyc();
    load_valid = 1'b0; sync_restart = 1'b1; cyc();
    sync_restart = 1'b0;
    chk("t4_low", 64'({clk_out[2], clk_out[0]}), 64'd0);
    wait_lvl(2, 1'b1, n);  chk("t4_ch2", 64'(n), 64'd2);
    wait_lvl(0, 1'b1, n);  chk("t4_ch0", 64'(n), 64'd2);
    chk("t4_align", 64'(fall_tick[2]), 64'd1);

    // Disable ch2 while high: forced low with no fall tick.
    wait_lvl(2, 1'b1, n);
    ch_en[2] = 1'b0; cyc();
    chk("t5_low", 64'(clk_out[2]), 64'd0);
    chk("t5_ntick", 64'(fall_tick[2]), 64'd0);
    cyc(); cyc();
    ch_en[2] = 1'b1;
    wait_lvl(2, 1'b1, n);  chk("t5_reen", 64'(n), 64'd2);

    // All-ones divisor is legal: stays low, no spurious toggle.
    load_valid = 1'b1; load_ch = 2'd1; load_m = 32'hFFFF_FFFF; cyc();
    load_valid = 1'b0; sync_restart = 1'b1; cyc();
    sync_restart = 1'b0;
    repeat (20) cyc();
    chk("mmax_low", 64'(clk_out[1]), 64'd0);
    load_valid = 1'b1; load_m = 32'd2; cyc();
    load_valid = 1'b0; sync_restart = 1'b1; cyc();
    sync_restart = 1'b0;

    // Random traffic, scoreboard only.
    for (int k = 0; k < 300; k++) begin
      load_valid   = ($urandom_range(0, 2) == 0);
      load_ch      = LCH_W'($urandom_range(0, 3));
      load_m       = 32'($urandom_range(0, 6));
      sync_restart = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) ch_en = NUM_CH'($urandom_range(0, 7));
      cyc();
    end

    // Reset with a pending load, then an unmapped load.
    ch_en = '1; load_valid = 1'b0; sync_restart = 1'b1; cyc();
    sync_restart = 1'b0;
    load_valid = 1'b1; load_ch = 2'd0; load_m = 32'd5; cyc();
    load_valid = 1'b0;
    cyc(); cyc();
    #1 chk("t6_pend", 64'(load_ready), 64'd0);
    rst_n = 1'b0; cyc();
    chk("t6_clk", 64'(clk_out), 64'd0);
    chk("t6_rdy", 64'(load_ready), 64'd1);
    rst_n = 1'b1; load_valid = 1'b1; load_ch = 2'd3; load_m = 32'd0;
    #1 chk("t6_oor", 64'(load_ready), 64'd1);
    cyc();
    load_valid = 1'b0;
    wait_lvl(0, 1'b1, n);  chk("t6_m7", 64'(n), 64'd7);
    repeat (30) cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
